controller_digit_emit: RTL

CONTROLLER_DIGIT_EMIT -- requirements
Module: controller_digit_emit

---
 rtl/controller_digit_emit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/controller_digit_emit.sv
// Binary-to-BCD (double dabble) converter that streams decimal digits MSD first; DIGIT_EMIT_LZS_EN skips leading zeros.
// Latency: W+1 cycles from start accept to first digit_valid (plus one cycle per skipped zero with DIGIT_EMIT_LZS_EN).
// Backpressure: digit holds while digit_ready=0; start is ignored while busy.
module controller_digit_emit #(
    parameter int W    = 16,
    parameter int NDIG = 5
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         start,
    input  logic [W-1:0] number,
    output logic         busy,
    output logic         digit_valid,
    output logic [3:0]   digit,
    input  logic         digit_ready,
    output logic         done
);

    localparam int BW = 4 * NDIG;
    localparam int CW = $clog2(W + 1);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q;
    logic [W-1:0]    bin_q;
    logic [BW-1:0]   bcd_q;
    logic [BW-1:0]   bcd_adj;
    logic [CW-1:0]   cnt_q;
    logic [IW-1:0]   idx_q;
    logic            busy_q;
    logic            vld_q;
    logic            done_q;
    logic [3:0]      digit_q;

    function automatic logic [3:0] nib(input logic [BW-1:0] v, input logic [IW-1:0] k);
        nib = 4'h0;
        for (int i = 0; i < NDIG; i++) begin
            if (k == IW'(i)) nib = v[4*i +: 4];
        end
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            digit_q <= 4'hf;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bin_q   <= number;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    bcd_q <= (bcd_adj << 1) | BW'(bin_q[W-1]);
                    bin_q <= bin_q << 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(W - 1)) begin
                        idx_q   <= IW'(NDIG - 1);
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    // First EMIT cycle(s) only load the output register; digit stays 4'hf until then.
                    if (!vld_q) begin
`ifdef DIGIT_EMIT_LZS_EN
                        if (idx_q != '0 && nib(bcd_q, idx_q) == 4'd0) begin
                            idx_q <= idx_q - 1'b1;
                        end else begin
                            vld_q   <= 1'b1;
                            digit_q <= nib(bcd_q, idx_q);
                        end
`else
                        vld_q   <= 1'b1;
                        digit_q <= nib(bcd_q, idx_q);
`endif
                    end else if (digit_ready) begin
                        if (idx_q == '0) begin
                            vld_q   <= 1'b0;
                            digit_q <= 4'hf;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q   <= idx_q - 1'b1;
                            digit_q <= nib(bcd_q, idx_q - 1'b1);
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign digit_valid = vld_q;
    assign digit       = digit_q;
    assign done        = done_q;

endmodule
